// File: rtl/chif_cycle_sched.sv
// Cycle scheduler between a byte-wide host bridge and a clock-gated DUT: collects a frame,
// runs the DUT for chif_simcycle cycles, then streams the response back LSB-first.
// Optional macro CHIF_SCHED_FRAME_CNT_EN adds a 32-bit completed-frame counter output.
module chif_cycle_sched #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 4
) (
    input  logic                   chif_clk,
    input  logic                   reset,
    input  logic [7:0]             chif_din,
    input  logic                   chif_din_valid,
    output logic                   chif_din_ready,
    input  logic [15:0]            chif_simcycle,
    output logic [7:0]             chif_dout,
    output logic                   chif_dout_valid,
    input  logic                   chif_dout_ready,
    output logic [8*IN_BYTES-1:0]  dut_in,
    output logic                   dut_clk_en,
    input  logic [8*OUT_BYTES-1:0] dut_out,
    output logic                   err_overrun
`ifdef CHIF_SCHED_FRAME_CNT_EN
    ,
    output logic [31:0]            frame_cnt
`endif
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [8:0]             byte_cnt;
    logic [15:0]            cyc_cnt;
    logic [8*IN_BYTES-1:0]  staging;
    logic [8*IN_BYTES-1:0]  staging_nxt;
    logic [8*OUT_BYTES-1:0] out_sr;
    logic                   last_in;
    logic                   last_out;

    // byte_cnt counts inbound bytes in COLLECT and outbound handshakes in EMIT
    assign last_in  = chif_din_valid && (byte_cnt == 9'(IN_BYTES - 1));
    assign last_out = chif_dout_ready && (byte_cnt == 9'(OUT_BYTES - 1));

    // Ready also counts the byte already in flight, given the one-cycle read latency
    assign chif_din_ready  = !reset && (state_q == COLLECT) &&
                             (({1'b0, byte_cnt} + {9'd0, chif_din_valid}) < 10'(IN_BYTES));
    assign chif_dout_valid = (state_q == EMIT);
    assign dut_clk_en      = (state_q == RUN);
    assign chif_dout       = out_sr[7:0];

    always_comb begin
        staging_nxt = staging;
        for (int i = 0; i < IN_BYTES; i++) begin
            if (byte_cnt == 9'(i)) staging_nxt[i*8 +: 8] = chif_din;
        end
    end

    always_ff @(posedge chif_clk) begin
        if (reset) state_q <= COLLECT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (last_in) state_d = RUN;
            RUN:     if (cyc_cnt <= 16'd1) state_d = CAPTURE;
            CAPTURE: state_d = EMIT;
            EMIT:    if (last_out) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge chif_clk) begin
        if (reset) begin
            byte_cnt    <= '0;
            cyc_cnt     <= '0;
            staging     <= '0;
            dut_in      <= '0;
            out_sr      <= '0;
            err_overrun <= 1'b0;
`ifdef CHIF_SCHED_FRAME_CNT_EN
            frame_cnt   <= '0;
`endif
        end else begin
            if (chif_din_valid && (state_q != COLLECT)) err_overrun <= 1'b1;
            case (state_q)
                COLLECT: begin
                    if (chif_din_valid) begin
                        staging <= staging_nxt;
                        if (last_in) begin
                            dut_in   <= staging_nxt;
                            byte_cnt <= '0;
                            // A zero cycle count still gives the DUT one enabled cycle
                            cyc_cnt  <= (chif_simcycle == 16'd0) ? 16'd1 : chif_simcycle;
                        end else begin
                            byte_cnt <= byte_cnt + 9'd1;
                        end
                    end
                end
                RUN: begin
                    cyc_cnt <= cyc_cnt - 16'd1;
                end
                CAPTURE: begin
                    out_sr <= dut_out;
                end
                EMIT: begin
                    if (chif_dout_ready) begin
                        out_sr <= out_sr >> 8;
                        if (last_out) begin
                            byte_cnt  <= '0;
`ifdef CHIF_SCHED_FRAME_CNT_EN
                            frame_cnt <= frame_cnt + 32'd1;
`endif
                        end else begin
                            byte_cnt <= byte_cnt + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chif_cycle_sched.sv
// Directed self-checking bench for chif_cycle_sched (IN_BYTES = OUT_BYTES = 4).
module tb_chif_cycle_sched;

    logic        chif_clk = 1'b0;
    logic        reset;
    logic [7:0]  chif_din;
    logic        chif_din_valid;
    logic        chif_din_ready;
    logic [15:0] chif_simcycle;
    logic [7:0]  chif_dout;
    logic        chif_dout_valid;
    logic        chif_dout_ready;
    logic [31:0] dut_in;
    logic        dut_clk_en;
    logic [31:0] dut_out;
    logic        err_overrun;
`ifdef CHIF_SCHED_FRAME_CNT_EN
    logic [31:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 chif_clk = ~chif_clk;

    chif_cycle_sched #(.IN_BYTES(4), .OUT_BYTES(4)) dut (
        .chif_clk        (chif_clk),
        .reset           (reset),
        .chif_din        (chif_din),
        .chif_din_valid  (chif_din_valid),
        .chif_din_ready  (chif_din_ready),
        .chif_simcycle   (chif_simcycle),
        .chif_dout       (chif_dout),
        .chif_dout_valid (chif_dout_valid),
        .chif_dout_ready (chif_dout_ready),
        .dut_in          (dut_in),
        .dut_clk_en      (dut_clk_en),
        .dut_out         (dut_out),
        .err_overrun     (err_overrun)
`ifdef CHIF_SCHED_FRAME_CNT_EN
        ,
        .frame_cnt       (frame_cnt)
`endif
    );

    // Drives four bytes back-to-back; returns at the first RUN cycle, then disturbs simcycle
    task automatic feed_frame(input logic [31:0] word, input logic [15:0] sim);
        chif_simcycle = sim;
        for (int i = 0; i < 4; i++) begin
            @(negedge chif_clk);
            chif_din       = word[i*8 +: 8];
            chif_din_valid = 1'b1;
        end
        @(negedge chif_clk);
        chif_din_valid = 1'b0;
        chif_din       = 8'h00;
        chif_simcycle  = 16'hFFFF;
    endtask

    // Counts consecutive enabled cycles; returns at the first disabled cycle (bounded)
    task automatic count_run(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (dut_clk_en !== 1'b1) break;
            n++;
            @(negedge chif_clk);
        end
    endtask

    // Accepts an outbound frame with ready held high; returns once valid drops (bounded)
    task automatic drain(output int nb, output logic [31:0] w);
        chif_dout_ready = 1'b1;
        nb = 0;
        w  = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge chif_clk);
            if (chif_dout_valid === 1'b1) begin
                if (nb < 4) w[nb*8 +: 8] = chif_dout;
                nb++;
            end else if (nb > 0) begin
                break;
            end
        end
        chif_dout_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge chif_clk);
        @(negedge chif_clk);
        checks++;
        if (chif_din_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b want 0", chif_din_ready);
        end
        reset = 1'b0;
        @(negedge chif_clk);
        checks++;
        if (dut_in !== 32'h0 || chif_dout !== 8'h00) begin
            errors++; $display("FAIL reset_data got dut_in=%h dout=%h want 0/0", dut_in, chif_dout);
        end
        checks++;
        if (chif_dout_valid !== 1'b0 || dut_clk_en !== 1'b0 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got valid=%b en=%b err=%b want 0/0/0",
                     chif_dout_valid, dut_clk_en, err_overrun);
        end
        checks++;
        if (chif_din_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready got %b want 1", chif_din_ready);
        end
    endtask

    task automatic test_basic;
        int n, nb;
        logic [31:0] w;
        dut_out = 32'h01020304;
        feed_frame(32'h44332211, 16'd3);
        checks++;
        if (dut_in !== 32'h44332211) begin
            errors++; $display("FAIL basic_dut_in got %h want 44332211", dut_in);
        end
        checks++;
        if (dut_clk_en !== 1'b1) begin
            errors++; $display("FAIL basic_en_start got %b want 1", dut_clk_en);
        end
        count_run(n);
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL basic_run_len got %0d want 3", n);
        end
        checks++;
        if (chif_dout_valid !== 1'b0) begin
            errors++; $display("FAIL basic_capture_valid got %b want 0", chif_dout_valid);
        end
        drain(nb, w);
        checks++;
        if (nb !== 4 || w !== 32'h01020304) begin
            errors++; $display("FAIL basic_emit got n=%0d w=%h want 4/01020304", nb, w);
        end
        checks++;
        if (chif_din_ready !== 1'b1) begin
            errors++; $display("FAIL basic_back_to_collect got ready=%b want 1", chif_din_ready);
        end
    endtask

    task automatic test_simcycle_zero;
        int n, nb;
        logic [31:0] w;
        dut_out = 32'hDEADBEEF;
        feed_frame(32'h55667788, 16'd0);
        count_run(n);
        checks++;
        if (n !== 1) begin
            errors++; $display("FAIL zero_run_len got %0d want 1", n);
        end
        drain(nb, w);
        checks++;
        if (nb !== 4 || w !== 32'hDEADBEEF) begin
            errors++; $display("FAIL zero_emit got n=%0d w=%h want 4/deadbeef", nb, w);
        end
    endtask

    task automatic test_stall;
        int n;
        logic [31:0] e;
        e = 32'hA1B2C3D4;
        dut_out = e;
        chif_dout_ready = 1'b0;
        feed_frame(32'h0A0B0C0D, 16'd2);
        count_run(n);
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL stall_run_len got %0d want 2", n);
        end
        @(negedge chif_clk);
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (chif_dout_valid !== 1'b1 || chif_dout !== 8'hD4) begin
                errors++;
                $display("FAIL stall_hold[%0d] got valid=%b dout=%h want 1/d4", s, chif_dout_valid, chif_dout);
            end
            @(negedge chif_clk);
        end
        chif_dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (chif_dout_valid !== 1'b1 || chif_dout !== e[i*8 +: 8]) begin
                errors++;
                $display("FAIL stall_emit[%0d] got valid=%b dout=%h want 1/%h", i, chif_dout_valid, chif_dout, e[i*8 +: 8]);
            end
            @(negedge chif_clk);
        end
        chif_dout_ready = 1'b0;
        checks++;
        if (chif_dout_valid !== 1'b0 || chif_din_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_done got valid=%b ready=%b want 0/1", chif_dout_valid, chif_din_ready);
        end
    endtask

    task automatic test_ready_flow;
        int accepted, nb;
        logic pend;
        logic [31:0] w;
        dut_out       = 32'h0BADF00D;
        chif_simcycle = 16'd20;
        accepted      = 0;
        pend          = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge chif_clk);
            chif_din_valid = pend;
            if (pend) begin
                chif_din = 8'(8'hA0 + accepted);
                accepted++;
            end
            #1;
            pend = chif_din_ready;
        end
        chif_din_valid = 1'b0;
        checks++;
        if (accepted !== 4) begin
            errors++; $display("FAIL flow_accepted got %0d want 4", accepted);
        end
        checks++;
        if (err_overrun !== 1'b0) begin
            errors++; $display("FAIL flow_overrun got %b want 0", err_overrun);
        end
        checks++;
        if (dut_in !== 32'hA3A2A1A0) begin
            errors++; $display("FAIL flow_dut_in got %h want a3a2a1a0", dut_in);
        end
        drain(nb, w);
        checks++;
        if (nb !== 4 || w !== 32'h0BADF00D) begin
            errors++; $display("FAIL flow_emit got n=%0d w=%h want 4/0badf00d", nb, w);
        end
    endtask

    task automatic test_overrun;
        int n, nb;
        logic [31:0] w;
        dut_out = 32'h12345678;
        feed_frame(32'hCAFEF00D, 16'd5);
        chif_din       = 8'hEE;
        chif_din_valid = 1'b1;
        @(negedge chif_clk);
        chif_din_valid = 1'b0;
        checks++;
        if (err_overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_flag got %b want 1", err_overrun);
        end
        checks++;
        if (dut_in !== 32'hCAFEF00D) begin
            errors++; $display("FAIL overrun_dut_in got %h want cafef00d", dut_in);
        end
        count_run(n);
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL overrun_run_rest got %0d want 4", n);
        end
        drain(nb, w);
        checks++;
        if (nb !== 4 || w !== 32'h12345678 || err_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_after got n=%0d w=%h err=%b want 4/12345678/1", nb, w, err_overrun);
        end
    endtask

    task automatic test_reset_emit;
        int n, seen;
        dut_out = 32'h87654321;
        feed_frame(32'h01010101, 16'd1);
        count_run(n);
        @(negedge chif_clk);
        checks++;
        if (chif_dout_valid !== 1'b1) begin
            errors++; $display("FAIL rst_emit_entered got %b want 1", chif_dout_valid);
        end
        reset           = 1'b1;
        chif_dout_ready = 1'b1;
        @(negedge chif_clk);
        checks++;
        if (chif_dout_valid !== 1'b0 || chif_din_ready !== 1'b0 || dut_clk_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_emit_ctrl got valid=%b ready=%b en=%b want 0/0/0",
                     chif_dout_valid, chif_din_ready, dut_clk_en);
        end
        checks++;
        if (err_overrun !== 1'b0 || dut_in !== 32'h0 || chif_dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_emit_clear got err=%b dut_in=%h dout=%h want 0/0/0", err_overrun, dut_in, chif_dout);
        end
        reset = 1'b0;
        seen  = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge chif_clk);
            if (chif_dout_valid === 1'b1) seen++;
        end
        chif_dout_ready = 1'b0;
        checks++;
        if (seen !== 0 || chif_din_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_no_partial got valid_cycles=%0d ready=%b want 0/1", seen, chif_din_ready);
        end
    endtask

`ifdef CHIF_SCHED_FRAME_CNT_EN
    task automatic test_frame_cnt;
        int n, nb;
        logic [31:0] w;
        @(negedge chif_clk);
        force dut.frame_cnt = 32'hFFFFFFFF;
        @(negedge chif_clk);
        release dut.frame_cnt;
        @(negedge chif_clk);
        checks++;
        if (frame_cnt !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL fcnt_preset got %h want ffffffff", frame_cnt);
        end
        dut_out = 32'h00000000;
        feed_frame(32'h11111111, 16'd1);
        count_run(n);
        drain(nb, w);
        checks++;
        if (frame_cnt !== 32'h0) begin
            errors++; $display("FAIL fcnt_wrap got %h want 0", frame_cnt);
        end
    endtask
`endif

    initial begin
        reset           = 1'b1;
        chif_din        = 8'h00;
        chif_din_valid  = 1'b0;
        chif_simcycle   = 16'd0;
        chif_dout_ready = 1'b0;
        dut_out         = 32'h0;
        test_reset();
        test_basic();
        test_simcycle_zero();
        test_stall();
        test_ready_flow();
        test_overrun();
        test_reset_emit();
`ifdef CHIF_SCHED_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
